// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the fetch stage: NOP encoding, FSM states,
// default memory depth, IF/ID slot layout and the fetch-address check.
package instruction_fetch_stage_pkg;

    localparam logic [31:0] NOP_ENC           = 32'h0000_0013;  // addi x0,x0,0
    localparam int          DEFAULT_MEM_WORDS = 32;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    // A fetch address is bad when misaligned or beyond the end of the instruction memory.
    function automatic logic fetch_bad(input logic [31:0] pc, input logic [31:0] words);
        return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= words);
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_pc_register.sv
// Program counter flop: async active-low reset to RESET_PC, loads next_pc when load is set.
module pc_register #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        gclk,
    input  logic        grst_n,
    input  logic        load,
    input  logic [31:0] next_pc,
    output logic [31:0] pc
);

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)   pc <= RESET_PC;
        else if (load) pc <= next_pc;
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC, next-PC selection, RUN/HALT fault FSM and the IF/ID pipeline register.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = DEFAULT_MEM_WORDS,
    parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] ReadAddress,
    input  logic [31:0] InstructionIn,
    output logic [31:0] IfIdInstruction,
    output logic [31:0] IfIdPC,
    output logic [31:0] IfIdPCPlus4,
    output logic        IfIdValid,
    output logic        FetchFault,
    output logic [31:0] FaultPC
);

    fetch_state_e state;
    if_id_t       ifid;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;
    logic         fault;
    logic         pc_load;

    assign pc_plus4    = pc + 32'd4;
    assign ReadAddress = {2'b00, pc[31:2]};
    assign fault       = (state == ST_RUN) && fetch_bad(pc, 32'(MEM_WORDS));
    // A branch overrides a stall; a fault or HALT freezes the PC.
    assign pc_load     = (state == ST_RUN) && !fault && (BranchTaken || !Stall);
    assign next_pc     = BranchTaken ? BranchTarget : pc_plus4;

    pc_register #(.RESET_PC(RESET_PC)) u_pc (
        .gclk    (Clock),
        .grst_n  (ResetN),
        .load    (pc_load),
        .next_pc (next_pc),
        .pc      (pc)
    );

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state      <= ST_RUN;
            ifid       <= '{instr: NOP_INSTR, pc: 32'd0, pc4: 32'd0, valid: 1'b0};
            FetchFault <= 1'b0;
            FaultPC    <= 32'd0;
        end else if (state == ST_RUN) begin
            if (fault) begin
                state       <= ST_HALT;
                FetchFault  <= 1'b1;
                FaultPC     <= pc;
                ifid.instr  <= NOP_INSTR;
                ifid.valid  <= 1'b0;
            end else if (BranchTaken || Flush) begin
                // Under a stall the flush still kills the slot while the PC holds.
                ifid.instr  <= NOP_INSTR;
                ifid.valid  <= 1'b0;
            end else if (!Stall) begin
                ifid <= '{instr: InstructionIn, pc: pc, pc4: pc_plus4, valid: 1'b1};
            end
        end
    end

    assign IfIdInstruction = ifid.instr;
    assign IfIdPC          = ifid.pc;
    assign IfIdPCPlus4     = ifid.pc4;
    assign IfIdValid       = ifid.valid;

endmodule
